// File: rtl/user_proj_ex_if.sv
// rtl/user_proj_ex_if.sv - Wishbone slave bus bundle for user_proj_ex
// Purpose: groups the Wishbone strobe/cycle/write/select/address/data request
//   signals and the ack/read-data response into one port.
// Signals: wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i[3:0], wbs_adr_i[31:0],
//   wbs_dat_i[BITS-1:0] (master -> slave); wbs_ack_o, wbs_dat_o[BITS-1:0]
//   (slave -> master).
interface user_proj_ex_if #(
  parameter int BITS = 32
);
  logic            wbs_stb_i;
  logic            wbs_cyc_i;
  logic            wbs_we_i;
  logic [3:0]      wbs_sel_i;
  logic [31:0]     wbs_adr_i;
  logic [BITS-1:0] wbs_dat_i;
  logic            wbs_ack_o;
  logic [BITS-1:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/user_proj_ex.sv
// rtl/user_proj_ex.sv - Wishbone front end of the KD-tree ANN accelerator
// Purpose: control/status registers, host-loadable query/leaf/best/node
//   memories and a fixed-latency search FSM.
// Ports: wb_clk_i clock; rst_n async active-low reset; wb Wishbone slave
//   bundle; la_data_in/la_oenb unused; la_data_out status mirror; io_in unused;
//   io_out {done,busy} at [31:30]; io_oeb pad enables (0 = drive); irq[0] done
//   pulse.
// Option: USER_PROJ_LA_STATUS_EN mirrors {debug,mode,busy,done} on la_data_out.
module user_proj_ex #(
  parameter int BITS        = 32,
  parameter int DATA_WIDTH  = 11,
  parameter int NUM_LEAVES  = 64,
  parameter int LEAF_SIZE   = 8,
  parameter int NUM_QUERYS  = 494,
  parameter int FSM_LATENCY = 64
) (
  input  logic          wb_clk_i,
  input  logic          rst_n,
  user_proj_ex_if.slave wb,
  input  logic [127:0]  la_data_in,
  input  logic [127:0]  la_oenb,
  output logic [127:0]  la_data_out,
  input  logic [37:0]   io_in,
  output logic [37:0]   io_out,
  output logic [37:0]   io_oeb,
  output logic [2:0]    irq
);
  localparam int LEAF_DEPTH = NUM_LEAVES * LEAF_SIZE;
  localparam int QAW = $clog2(NUM_QUERYS);
  localparam int LAW = $clog2(LEAF_DEPTH);
  localparam int NAW = $clog2(NUM_LEAVES);
  localparam int CW  = $clog2(FSM_LATENCY);
  localparam logic [CW-1:0] CNT_LAST = CW'(FSM_LATENCY - 1);
  localparam logic [12:0] Q_LIM = 13'(NUM_QUERYS);
  localparam logic [12:0] L_LIM = 13'(LEAF_DEPTH);
  localparam logic [9:0]  B_LIM = 10'(NUM_QUERYS);
  localparam logic [15:0] PG_CTRL  = 16'h3000;
  localparam logic [15:0] PG_QUERY = 16'h3001;
  localparam logic [15:0] PG_LEAF  = 16'h3002;
  localparam logic [15:0] PG_BEST  = 16'h3003;
  localparam logic [15:0] PG_NODE  = 16'h3004;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic            debug_q, debug_d;
  logic            done_q, done_d;
  logic            irq0_q, irq0_d;
  logic            ack_q, ack_d;
  logic [BITS-1:0] dat_q, dat_d;

  // Memories are not reset; their contents are undefined until the host loads them.
  logic [31:0]             query_lo [NUM_QUERYS];
  logic [22:0]             query_hi [NUM_QUERYS];
  logic [31:0]             leaf_lo  [LEAF_DEPTH];
  logic [31:0]             leaf_hi  [LEAF_DEPTH];
  logic [DATA_WIDTH-1:0]   best_mem [NUM_QUERYS];
  logic [2*DATA_WIDTH-1:0] node_mem [NUM_LEAVES];

  logic [15:0]     page, offs;
  logic [12:0]     word_idx;
  logic [9:0]      best_idx;
  logic [NAW-1:0]  node_idx;
  logic            half, hit, access, wr, rd, busy, start;
  logic            q_ok, l_ok, b_ok;
  logic [BITS-1:0] rdata;

  always_comb begin
    page     = wb.wbs_adr_i[31:16];
    offs     = wb.wbs_adr_i[15:0];
    word_idx = wb.wbs_adr_i[15:3];
    half     = wb.wbs_adr_i[2];
    best_idx = wb.wbs_adr_i[11:2];
    node_idx = wb.wbs_adr_i[NAW-1:0];
    hit      = wb.wbs_cyc_i & wb.wbs_stb_i & (page >= PG_CTRL) & (page <= PG_NODE);
    // The access commits on the edge that raises ack; the cycle after an ack
    // never re-commits, so a held strobe becomes a train of separate accesses.
    access   = hit & ~ack_q & rst_n;
    wr       = access & wb.wbs_we_i;
    rd       = access & ~wb.wbs_we_i;
    q_ok     = word_idx < Q_LIM;
    l_ok     = word_idx < L_LIM;
    b_ok     = best_idx < B_LIM;
  end

  assign busy = (state_q == S_RUN);

  always_ff @(posedge wb_clk_i) begin
    if (wr && page == PG_QUERY && q_ok) begin
      if (half) query_hi[word_idx[QAW-1:0]] <= wb.wbs_dat_i[22:0];
      else      query_lo[word_idx[QAW-1:0]] <= wb.wbs_dat_i[31:0];
    end
    if (wr && page == PG_LEAF && l_ok) begin
      if (half) leaf_hi[word_idx[LAW-1:0]] <= wb.wbs_dat_i[31:0];
      else      leaf_lo[word_idx[LAW-1:0]] <= wb.wbs_dat_i[31:0];
    end
    if (wr && page == PG_BEST && b_ok && debug_q)
      best_mem[best_idx[QAW-1:0]] <= wb.wbs_dat_i[DATA_WIDTH-1:0];
    // Node 0 does not exist in the tree (nodes are 1..NUM_LEAVES-1).
    if (wr && page == PG_NODE && node_idx != '0)
      node_mem[node_idx] <= wb.wbs_dat_i[2*DATA_WIDTH-1:0];
  end

  always_comb begin
    rdata = '0;
    case (page)
      PG_CTRL: begin
        case (offs)
          16'h0000: rdata = BITS'(mode_q);
          16'h0004: rdata = BITS'(debug_q);
          16'h0008: rdata = BITS'(done_q);
          16'h0010: rdata = BITS'(busy);
          default:  rdata = '0;
        endcase
      end
      PG_QUERY: if (debug_q && q_ok)
        rdata = half ? BITS'(query_hi[word_idx[QAW-1:0]]) : BITS'(query_lo[word_idx[QAW-1:0]]);
      PG_LEAF: if (debug_q && l_ok)
        rdata = half ? BITS'(leaf_hi[word_idx[LAW-1:0]]) : BITS'(leaf_lo[word_idx[LAW-1:0]]);
      PG_BEST: if (b_ok)
        rdata = BITS'(best_mem[best_idx[QAW-1:0]]);
      PG_NODE: if (debug_q && node_idx != '0)
        rdata = BITS'(node_mem[node_idx]);
      default: rdata = '0;
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    debug_d = debug_q;
    done_d  = done_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    irq0_d  = 1'b0;
    start   = 1'b0;
    ack_d   = hit & ~ack_q;
    dat_d   = rd ? rdata : '0;
    if (wr && page == PG_CTRL) begin
      case (offs)
        16'h0000: mode_d  = wb.wbs_dat_i[1:0];
        16'h0004: debug_d = wb.wbs_dat_i[0];
        16'h0008: if (wb.wbs_dat_i[0]) done_d = 1'b0;
        16'h000C: start   = wb.wbs_dat_i[0];
        default:  ;
      endcase
    end
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        cnt_d   = '0;
        done_d  = 1'b0;
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          irq0_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      debug_q <= 1'b0;
      done_q  <= 1'b0;
      irq0_q  <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      debug_q <= debug_d;
      done_q  <= done_d;
      irq0_q  <= irq0_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign io_out = {6'b0, done_q, busy, 30'b0};
  assign io_oeb = {6'h3F, 2'b00, 30'h3FFF_FFFF};
  assign irq    = {2'b00, irq0_q};

`ifdef USER_PROJ_LA_STATUS_EN
  assign la_data_out = {123'b0, debug_q, mode_q, busy, done_q};
`else
  assign la_data_out = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{wb.wbs_sel_i, la_data_in, la_oenb, io_in};
endmodule

// File: tb/tb_user_proj_ex.sv
// tb/tb_user_proj_ex.sv - self-checking bench for user_proj_ex
module tb_user_proj_ex;
  localparam int LAT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] la_data_in, la_oenb, la_data_out;
  logic [37:0]  io_in, io_out, io_oeb;
  logic [2:0]   irq;

  user_proj_ex_if #(.BITS(32)) wb ();

  user_proj_ex dut (
    .wb_clk_i    (clk),
    .rst_n       (rst_n),
    .wb          (wb),
    .la_data_in  (la_data_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_data_out),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .irq         (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: edge count, last start/clear edges, register shadows, memory contents.
  int          cyc_cnt = 0;
  int          start_c = -1;
  int          clear_c = -1;
  logic [1:0]  m_mode  = 2'd0;
  logic        m_debug = 1'b0;
  logic [31:0] qlo [int];
  logic [31:0] qhi [int];
  logic [31:0] llo [int];
  logic [31:0] lhi [int];
  logic [31:0] bst [int];
  logic [31:0] nod [int];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic f_busy(input int t);
    return (start_c >= 0) && (t >= start_c) && (t < start_c + LAT);
  endfunction

  function automatic logic f_done(input int t);
    return (start_c >= 0) && (t >= start_c + LAT) && (clear_c < start_c + LAT);
  endfunction

  function automatic void m_reset();
    start_c = -1;
    clear_c = -1;
    m_mode  = 2'd0;
    m_debug = 1'b0;
  endfunction

  // Applied when the write is acked; cyc_cnt is then the number of the committing edge.
  function automatic void m_write(input logic [31:0] a, input logic [31:0] d);
    int w = int'(a[15:3]);
    int b = int'(a[11:2]);
    int n = int'(a[5:0]);
    case (a[31:16])
      16'h3000: begin
        if (a[15:0] == 16'h0000) m_mode = d[1:0];
        if (a[15:0] == 16'h0004) m_debug = d[0];
        if (a[15:0] == 16'h0008 && d[0]) clear_c = cyc_cnt;
        if (a[15:0] == 16'h000C && d[0] && !f_busy(cyc_cnt - 1)) start_c = cyc_cnt;
      end
      16'h3001: if (w < 494) begin
        if (a[2]) qhi[w] = d & 32'h007F_FFFF;
        else      qlo[w] = d;
      end
      16'h3002: if (w < 512) begin
        if (a[2]) lhi[w] = d;
        else      llo[w] = d;
      end
      16'h3003: if (b < 494 && m_debug) bst[b] = d & 32'h0000_07FF;
      16'h3004: if (n != 0) nod[n] = d & 32'h003F_FFFF;
      default: ;
    endcase
  endfunction

  // Read data reflects register state before the committing edge.
  function automatic logic [31:0] m_read(input logic [31:0] a);
    int t = cyc_cnt - 1;
    int w = int'(a[15:3]);
    int b = int'(a[11:2]);
    int n = int'(a[5:0]);
    logic [31:0] r = 32'h0;
    case (a[31:16])
      16'h3000: begin
        if (a[15:0] == 16'h0000) r = {30'b0, m_mode};
        if (a[15:0] == 16'h0004) r = {31'b0, m_debug};
        if (a[15:0] == 16'h0008) r = {31'b0, f_done(t)};
        if (a[15:0] == 16'h0010) r = {31'b0, f_busy(t)};
      end
      16'h3001: if (m_debug && w < 494) begin
        if (a[2] && qhi.exists(w)) r = qhi[w];
        if (!a[2] && qlo.exists(w)) r = qlo[w];
      end
      16'h3002: if (m_debug && w < 512) begin
        if (a[2] && lhi.exists(w)) r = lhi[w];
        if (!a[2] && llo.exists(w)) r = llo[w];
      end
      16'h3003: if (b < 494 && bst.exists(b)) r = bst[b];
      16'h3004: if (m_debug && n != 0 && nod.exists(n)) r = nod[n];
      default: ;
    endcase
    return r;
  endfunction

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic got = 1'b0;
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
    wb.wbs_adr_i = a; wb.wbs_dat_i = d;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (wb.wbs_ack_o) got = 1'b1;
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    if (got) m_write(a, d);
    check($sformatf("wr_ack_%h", a), got, 1'b1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] got_d);
    logic got = 1'b0;
    got_d = 32'h0;
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0; wb.wbs_adr_i = a;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (wb.wbs_ack_o) begin
        got = 1'b1;
        got_d = wb.wbs_dat_o;
        check($sformatf("rd_model_%h", a), got_d, m_read(a));
      end
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    check($sformatf("rd_ack_%h", a), got, 1'b1);
  endtask

  task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] lit);
    logic [31:0] v;
    wb_read(a, v);
    check(name, v, lit);
  endtask

  task automatic wb_hold_write(input logic [31:0] a, input logic [31:0] d, input int ncyc,
                               output int acks);
    acks = 0;
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
    wb.wbs_adr_i = a; wb.wbs_dat_i = d;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (wb.wbs_ack_o) begin
        acks++;
        m_write(a, d);
      end
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
  endtask

  // Per-cycle compare of all outputs against the model.
  initial begin
    logic ack_exp = 1'b0;
    logic sel_now;
    logic [127:0] la_exp;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) ack_exp = 1'b0;
      check("ack", wb.wbs_ack_o, ack_exp);
      if (!wb.wbs_ack_o) check("dat_idle", wb.wbs_dat_o, 32'h0);
      check("io_out", io_out, {6'b0, f_done(cyc_cnt), f_busy(cyc_cnt), 30'b0});
      check("irq", irq, {2'b0, (start_c >= 0) && (cyc_cnt == start_c + LAT)});
      check("io_oeb", io_oeb, 38'h3F_3FFF_FFFF);
`ifdef USER_PROJ_LA_STATUS_EN
      la_exp = {123'b0, m_debug, m_mode, f_busy(cyc_cnt), f_done(cyc_cnt)};
`else
      la_exp = 128'h0;
`endif
      check("la_data_out", la_data_out, la_exp);
      sel_now = wb.wbs_cyc_i && wb.wbs_stb_i &&
                (wb.wbs_adr_i[31:16] >= 16'h3000) && (wb.wbs_adr_i[31:16] <= 16'h3004);
      ack_exp = rst_n && sel_now && !ack_exp;
    end
  end

  initial begin
    int acks;
    int irq_cnt;
    logic [31:0] v;
    logic got;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = 32'h0; wb.wbs_dat_i = 32'h0;
    la_data_in = '0; la_oenb = '0; io_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    rd_lit("mode_reset", 32'h3000_0000, 32'h0);
    rd_lit("done_reset", 32'h3000_0008, 32'h0);
    rd_lit("busy_reset", 32'h3000_0010, 32'h0);

    wb_hold_write(32'h3000_0004, 32'h1, 10, acks);
    check("debug_held_acks", acks, 5);
    wb_hold_write(32'h3000_0000, 32'h1, 10, acks);
    check("mode_held_acks", acks, 5);
    rd_lit("debug_rb", 32'h3000_0004, 32'h1);
    rd_lit("mode_rb", 32'h3000_0000, 32'h1);
    rd_lit("unmapped_ctrl", 32'h3000_0020, 32'h0);

    for (int n = 1; n < 64; n++)
      wb_write(32'h3004_0000 | n, ((n + 100) << 11) | (n * 7));
    rd_lit("node5", 32'h3004_0005, 32'h0003_4823);
    wb_write(32'h3004_0000, 32'h003F_FFFF);
    rd_lit("node1_after_n0", 32'h3004_0001, 32'h0003_2807);

    wb_write(32'h3002_0018, 32'h1234_5678);
    wb_write(32'h3002_001C, 32'h9ABC_DEF0);
    rd_lit("leaf3_h0", 32'h3002_0018, 32'h1234_5678);
    rd_lit("leaf3_h1", 32'h3002_001C, 32'h9ABC_DEF0);
    wb_write(32'h3002_0FF8, 32'hCAFE_F00D);
    rd_lit("leaf511_h0", 32'h3002_0FF8, 32'hCAFE_F00D);
    wb_write(32'h3002_12C0, 32'h1111_1111);
    wb_write(32'h3002_12C4, 32'h2222_2222);
    rd_lit("leaf600_h0", 32'h3002_12C0, 32'h0);
    rd_lit("leaf600_h1", 32'h3002_12C4, 32'h0);

    wb_write(32'h3001_0004, 32'hFFFF_FFFF);
    rd_lit("query0_h1", 32'h3001_0004, 32'h007F_FFFF);
    wb_write(32'h3001_0F68, 32'h55AA_55AA);
    rd_lit("query493_h0", 32'h3001_0F68, 32'h55AA_55AA);
    wb_write(32'h3001_0F70, 32'h7777_7777);
    rd_lit("query494_h0", 32'h3001_0F70, 32'h0);

    wb_write(32'h3003_0008, 32'h0000_FFFF);
    rd_lit("best2", 32'h3003_0008, 32'h0000_07FF);
    rd_lit("best500", 32'h3003_07D0, 32'h0);

    wb_write(32'h3000_0004, 32'h0);
    wb_write(32'h3003_0008, 32'h0000_0123);
    rd_lit("best2_locked", 32'h3003_0008, 32'h0000_07FF);
    rd_lit("query_nodebug", 32'h3001_0004, 32'h0);
    rd_lit("leaf_nodebug", 32'h3002_0018, 32'h0);
    rd_lit("node_nodebug", 32'h3004_0005, 32'h0);

    wb_write(32'h3000_000C, 32'h1);
    rd_lit("busy_run", 32'h3000_0010, 32'h1);
    wb_write(32'h3000_000C, 32'h1);
    irq_cnt = 0;
    repeat (70) begin
      @(negedge clk);
      #2;
      if (irq[0]) irq_cnt++;
    end
    check("irq_pulses", irq_cnt, 1);
    rd_lit("busy_end", 32'h3000_0010, 32'h0);
    rd_lit("done_end", 32'h3000_0008, 32'h1);
    wb_write(32'h3000_0008, 32'h1);
    rd_lit("done_clr", 32'h3000_0008, 32'h0);

    got = 1'b0;
    @(negedge clk);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
    wb.wbs_adr_i = 32'h3100_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wb.wbs_ack_o) got = 1'b1;
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    check("no_ack_3100", got, 1'b0);

    wb_write(32'h3000_0000, 32'h2);
    wb_write(32'h3000_000C, 32'h1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_lit("busy_after_rst", 32'h3000_0010, 32'h0);
    rd_lit("done_after_rst", 32'h3000_0008, 32'h0);
    rd_lit("mode_after_rst", 32'h3000_0000, 32'h0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
